// File: rtl/wvb_reader.sv
// ---------------------------------------------------------------------------
// wvb_reader
//   Drains one channel's waveform buffer. For each event it pops one header
//   from the header FIFO, reads the waveform's data words one at a time,
//   releases the waveform with wvb_rddone, and emits the whole event as one
//   16-bit valid/ready packet for the readout bridge.
//
//   Packet layout (length 5 + 2*n_words):
//     H0=hdr[79:64] (sop), H1=hdr[63:48], H2=hdr[47:32], H3=hdr[31:16],
//     H4=hdr[15:0], then per data word w: Dhi={10'b0,w[21:16]}, Dlo=w[15:0].
//     eop is on H4 when n_words==0, otherwise on the last Dlo.
//
//   Handshake: a word transfers on a rising edge where out_valid && out_ready.
//   While out_valid is high and out_ready is low, out_data/out_sop/out_eop
//   hold their values and out_valid stays high until the transfer happens.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   en           level enable for starting a new event
//   hdr_data     header FIFO head (first-word-fall-through)
//   hdr_empty    header FIFO empty
//   hdr_rdreq    one-cycle header pop
//   wvb_data     buffer read data, valid one cycle after wvb_rdreq
//   wvb_rdreq    one-cycle read of the next data word
//   wvb_rddone   one-cycle pulse: current waveform fully read
//   out_data     packet word
//   out_valid    out_data valid
//   out_sop      first word of packet (with out_valid)
//   out_eop      last word of packet (with out_valid)
//   out_ready    sink ready
//   busy         high from header pop through wvb_rddone
//   evt_cnt      completed events, wraps
//   dbg_state    current FSM state encoding
// ---------------------------------------------------------------------------
module wvb_reader #(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_ADR_WIDTH  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    input  logic                    hdr_empty,
    output logic                    hdr_rdreq,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic                    wvb_rdreq,
    output logic                    wvb_rddone,
    output logic [15:0]             out_data,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [15:0]             evt_cnt,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_DHI  = 3'd4,
        S_DLO  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [P_HDR_WIDTH-1:0]   hdr_reg;
    logic [2:0]               hdr_idx;
    logic [P_ADR_WIDTH-1:0]   remaining;
    logic [P_DATA_WIDTH-1:0]  word_reg;
    logic [P_ADR_WIDTH-1:0]   n_words;
    logic                     start;
    logic                     xfer;

    assign n_words = hdr_reg[P_ADR_WIDTH-1:0];
    assign start   = en && !hdr_empty;
    assign xfer    = out_valid && out_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_HDR;
            S_HDR: begin
                if (xfer && hdr_idx == 3'd4) begin
                    state_nxt = (n_words == '0) ? S_DONE : S_RD;
                end
            end
            S_RD:   state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_DHI;
            S_DHI:  if (xfer) state_nxt = S_DLO;
            S_DLO: begin
                if (xfer) state_nxt = (remaining != '0) ? S_RD : S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers. hdr_rdreq is registered so that it is 0 while rst
    // is asserted; the FIFO is only ever popped by this block, so it is still
    // non-empty in the cycle after the start condition was seen.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_reg   <= '0;
            hdr_idx   <= '0;
            remaining <= '0;
            word_reg  <= '0;
            hdr_rdreq <= 1'b0;
            evt_cnt   <= '0;
        end else begin
            hdr_rdreq <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hdr_reg   <= hdr_data;
                        hdr_idx   <= '0;
                        hdr_rdreq <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        if (hdr_idx == 3'd4) remaining <= n_words;
                        else                 hdr_idx   <= hdr_idx + 3'd1;
                    end
                end
                // Decrement at the read so that remaining==0 marks the last Dlo.
                S_RD:   remaining <= remaining - 1'b1;
                S_WAIT: word_reg  <= wvb_data;
                S_DONE: evt_cnt   <= evt_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registers only, so no input reaches an output
    // combinationally and everything is 0 in reset (state IDLE, regs clear).
    // -----------------------------------------------------------------------
    assign out_valid  = (state == S_HDR) || (state == S_DHI) || (state == S_DLO);
    assign out_sop    = (state == S_HDR) && (hdr_idx == 3'd0);
    assign out_eop    = ((state == S_HDR) && (hdr_idx == 3'd4) && (n_words == '0)) ||
                        ((state == S_DLO) && (remaining == '0));
    assign wvb_rdreq  = (state == S_RD);
    assign wvb_rddone = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

    always_comb begin
        out_data = '0;
        case (state)
            S_HDR: begin
                case (hdr_idx)
                    3'd0:    out_data = hdr_reg[79:64];
                    3'd1:    out_data = hdr_reg[63:48];
                    3'd2:    out_data = hdr_reg[47:32];
                    3'd3:    out_data = hdr_reg[31:16];
                    default: out_data = hdr_reg[15:0];
                endcase
            end
            S_DHI:   out_data = {10'b0, word_reg[21:16]};
            S_DLO:   out_data = word_reg[15:0];
            default: out_data = '0;
        endcase
    end

endmodule
